// File: rtl/rng_pkg.sv
// rtl/rng_pkg.sv - shared types and constants for the range-limited LFSR generator
//
// Purpose : FSM state encoding, default Fibonacci tap masks for common widths,
//           and the default nonzero seed.
// Ports   : none (package).
package rng_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MIX   = 2'd1,
      CHECK = 2'd2,
      HOLD  = 2'd3
   } rng_state_t;

   // Feedback masks for next = {state[W-2:0], ^(state & TAPS)}
   localparam logic [7:0]  TAPS_8  = 8'hB8;
   localparam logic [12:0] TAPS_13 = 13'h10A9;
   localparam logic [15:0] TAPS_16 = 16'hD008;
   localparam logic [31:0] TAPS_32 = 32'h80200003;

   localparam logic [12:0] SEED_DEFAULT = 13'h000F;

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - free-running Fibonacci LFSR with synchronous seed load
//
// Purpose : shifts every cycle; a load takes priority over the shift, and a
//           zero load value is replaced by SEED so the register never locks up.
// Ports   : i_clk          clock, rising edge
//           i_rst_n        asynchronous active-low reset (state <= SEED)
//           i_load         load i_load_value this cycle
//           i_load_value   new state (0 substituted by SEED)
//           o_state        current LFSR state
module lfsr_core #(
   parameter int            W    = 13,
   parameter logic [W-1:0]  TAPS = 13'h10A9,
   parameter logic [W-1:0]  SEED = 13'h000F
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_value,
   output logic [W-1:0] o_state
);

   logic [W-1:0] r_state;
   logic         w_feedback;

   assign w_feedback = ^(r_state & TAPS);
   assign o_state    = r_state;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= SEED;
      end else if (i_load) begin
         r_state <= (i_load_value == '0) ? SEED : i_load_value;
      end else begin
         r_state <= {r_state[W-2:0], w_feedback};
      end
   end

endmodule

// File: rtl/lfsr_range_rng.sv
// rtl/lfsr_range_rng.sv - uniform [0, RANGE-1] draws from a free-running LFSR
//
// Purpose : serves one draw per request through a valid/ready handshake using
//           rejection sampling with MAX_TRIES attempts and a modulo fallback.
//           Optional macro RNG_STATS_EN adds saturating draw/reject counters.
// Ports   : clock       system clock, rising edge
//           reset       asynchronous active-low reset
//           seed_load   load seed_in into the LFSR this cycle
//           seed_in     new seed (0 replaced by SEED)
//           req         draw request, sampled in IDLE
//           out_ready   consumer accepts out_data
//           out_valid   out_data valid, held until accepted
//           out_data    random value in [0, RANGE-1]
//           fallback    out_data came from the modulo fallback
//           busy        FSM not in IDLE
//           draw_cnt    (RNG_STATS_EN) accepted draws, saturating
//           reject_cnt  (RNG_STATS_EN) rejected candidates, saturating
//           state_q     current LFSR state
module lfsr_range_rng
   import rng_pkg::*;
#(
   parameter int                 LFSR_W     = 13,
   parameter logic [LFSR_W-1:0]  TAPS       = rng_pkg::TAPS_13,
   parameter logic [LFSR_W-1:0]  SEED       = rng_pkg::SEED_DEFAULT,
   parameter int                 OUT_W      = 4,
   parameter int                 RANGE      = 5,
   parameter int                 MIX_CYCLES = 13,
   parameter int                 MAX_TRIES  = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed_in,
   input  logic              req,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [OUT_W-1:0]  out_data,
   output logic              fallback,
   output logic              busy,
`ifdef RNG_STATS_EN
   output logic [15:0]       draw_cnt,
   output logic [15:0]       reject_cnt,
`endif
   output logic [LFSR_W-1:0] state_q
);

   localparam int MIX_W = $clog2(MIX_CYCLES + 1);
   localparam int TRY_W = $clog2(MAX_TRIES + 1);
   // One extra bit so RANGE = 2^OUT_W is representable in the compare
   localparam logic [OUT_W:0] C_RANGE = (OUT_W+1)'(RANGE);

   rng_state_t          r_fsm,   w_fsm_nxt;
   logic [MIX_W-1:0]    r_mix,   w_mix_nxt;
   logic [TRY_W-1:0]    r_tries, w_tries_nxt;
   logic                r_valid, w_valid_nxt;
   logic [OUT_W-1:0]    r_data,  w_data_nxt;
   logic                r_fb,    w_fb_nxt;

   logic [LFSR_W-1:0]   w_lfsr;
   logic [OUT_W:0]      w_cand_ext;
   logic                w_accept;
   logic [OUT_W-1:0]    w_mod;
   logic [TRY_W-1:0]    w_tries_inc;
   logic                w_reject;

   lfsr_core #(
      .W    (LFSR_W),
      .TAPS (TAPS),
      .SEED (SEED)
   ) u_lfsr (
      .i_clk        (clock),
      .i_rst_n      (reset),
      .i_load       (seed_load),
      .i_load_value (seed_in),
      .o_state      (w_lfsr)
   );

   assign w_cand_ext  = {1'b0, w_lfsr[OUT_W-1:0]};
   assign w_accept    = (w_cand_ext < C_RANGE);
   assign w_mod       = OUT_W'(w_cand_ext % C_RANGE);
   assign w_tries_inc = r_tries + TRY_W'(1);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_fsm   <= IDLE;
         r_mix   <= '0;
         r_tries <= '0;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_fb    <= 1'b0;
      end else begin
         r_fsm   <= w_fsm_nxt;
         r_mix   <= w_mix_nxt;
         r_tries <= w_tries_nxt;
         r_valid <= w_valid_nxt;
         r_data  <= w_data_nxt;
         r_fb    <= w_fb_nxt;
      end
   end

   always_comb begin
      w_fsm_nxt   = r_fsm;
      w_mix_nxt   = r_mix;
      w_tries_nxt = r_tries;
      w_valid_nxt = r_valid;
      w_data_nxt  = r_data;
      w_fb_nxt    = r_fb;
      w_reject    = 1'b0;
      case (r_fsm)
         IDLE: begin
            if (req) begin
               w_fsm_nxt   = MIX;
               w_mix_nxt   = '0;
               w_tries_nxt = '0;
            end
         end
         MIX: begin
            w_mix_nxt = r_mix + MIX_W'(1);
            if (r_mix == MIX_W'(MIX_CYCLES - 1)) begin
               w_fsm_nxt = CHECK;
            end
         end
         CHECK: begin
            if (w_accept) begin
               w_data_nxt  = w_lfsr[OUT_W-1:0];
               w_fb_nxt    = 1'b0;
               w_valid_nxt = 1'b1;
               w_fsm_nxt   = HOLD;
            end else begin
               w_reject    = 1'b1;
               w_tries_nxt = w_tries_inc;
               if (w_tries_inc == TRY_W'(MAX_TRIES)) begin
                  w_data_nxt  = w_mod;
                  w_fb_nxt    = 1'b1;
                  w_valid_nxt = 1'b1;
                  w_fsm_nxt   = HOLD;
               end else begin
                  w_mix_nxt = '0;
                  w_fsm_nxt = MIX;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               w_valid_nxt = 1'b0;
               w_fsm_nxt   = IDLE;
            end
         end
         default: begin
            w_fsm_nxt = IDLE;
         end
      endcase
   end

`ifdef RNG_STATS_EN
   logic [15:0] r_draw_cnt;
   logic [15:0] r_reject_cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_draw_cnt   <= '0;
         r_reject_cnt <= '0;
      end else begin
         if (r_valid && out_ready && (r_draw_cnt != 16'hFFFF)) begin
            r_draw_cnt <= r_draw_cnt + 16'd1;
         end
         if (w_reject && (r_reject_cnt != 16'hFFFF)) begin
            r_reject_cnt <= r_reject_cnt + 16'd1;
         end
      end
   end

   assign draw_cnt   = r_draw_cnt;
   assign reject_cnt = r_reject_cnt;
`endif

   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign fallback  = r_fb;
   assign busy      = (r_fsm != IDLE);
   assign state_q   = w_lfsr;

endmodule

// File: tb/tb_lfsr_range_rng.sv
// tb/tb_lfsr_range_rng.sv - scoreboard bench for lfsr_range_rng (three parameter sets)
module tb_lfsr_range_rng;

   localparam int N   = 3;
   localparam int MIX = 13;

   typedef struct {
      logic [3:0] d;
      bit         f;
      int         due;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        seed_load;
   logic [12:0] seed_in;
   logic        req       [N];
   logic        out_ready [N];
   logic        ov        [N];
   logic        fb        [N];
   logic        bsy       [N];
   logic [3:0]  od        [N];
   logic [12:0] sq        [N];
`ifdef RNG_STATS_EN
   logic [15:0] dc [N];
   logic [15:0] rc [N];
   int          m_draws [N];
   int          m_rej   [N];
`endif

   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;

   logic [12:0] m_state;
   bit          m_idle  [N];
   bit          m_valid [N];
   exp_t        m_cur   [N];
   exp_t        sb      [N][$];

   always #5 clock = ~clock;

   lfsr_range_rng u_a (
      .clock(clock), .reset(reset), .seed_load(seed_load), .seed_in(seed_in),
      .req(req[0]), .out_ready(out_ready[0]), .out_valid(ov[0]), .out_data(od[0]),
      .fallback(fb[0]), .busy(bsy[0]),
`ifdef RNG_STATS_EN
      .draw_cnt(dc[0]), .reject_cnt(rc[0]),
`endif
      .state_q(sq[0]));

   lfsr_range_rng #(.RANGE(16)) u_b (
      .clock(clock), .reset(reset), .seed_load(seed_load), .seed_in(seed_in),
      .req(req[1]), .out_ready(out_ready[1]), .out_valid(ov[1]), .out_data(od[1]),
      .fallback(fb[1]), .busy(bsy[1]),
`ifdef RNG_STATS_EN
      .draw_cnt(dc[1]), .reject_cnt(rc[1]),
`endif
      .state_q(sq[1]));

   lfsr_range_rng #(.MAX_TRIES(1)) u_c (
      .clock(clock), .reset(reset), .seed_load(seed_load), .seed_in(seed_in),
      .req(req[2]), .out_ready(out_ready[2]), .out_valid(ov[2]), .out_data(od[2]),
      .fallback(fb[2]), .busy(bsy[2]),
`ifdef RNG_STATS_EN
      .draw_cnt(dc[2]), .reject_cnt(rc[2]),
`endif
      .state_q(sq[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [12:0] step(input logic [12:0] s);
      return {s[11:0], ^(s & 13'h10A9)};
   endfunction

   function automatic int rng_of(input int i);
      return (i == 1) ? 16 : 5;
   endfunction

   function automatic int tries_of(input int i);
      return (i == 2) ? 1 : 4;
   endfunction

   // Candidate t is seen MIX shifts after the sampling edge, then every MIX+1
   task automatic predict(input int i);
      logic [12:0] s;
      exp_t        e;
      s = m_state;
      for (int t = 0; t < tries_of(i); t++) begin
         for (int k = 0; k < ((t == 0) ? MIX : MIX + 1); k++) s = step(s);
         e.due = cyc + (MIX + 1) * (t + 1);
         if (int'(s[3:0]) < rng_of(i)) begin
            e.d = s[3:0];
            e.f = 1'b0;
            sb[i].push_back(e);
            return;
         end
`ifdef RNG_STATS_EN
         m_rej[i]++;
`endif
         if (t == tries_of(i) - 1) begin
            e.d = 4'(int'(s[3:0]) % rng_of(i));
            e.f = 1'b1;
            sb[i].push_back(e);
         end
      end
   endtask

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_state = 13'h000F;
         for (int i = 0; i < N; i++) begin
            m_idle[i]  = 1'b1;
            m_valid[i] = 1'b0;
            sb[i].delete();
`ifdef RNG_STATS_EN
            m_draws[i] = 0;
            m_rej[i]   = 0;
`endif
         end
      end else begin
         cyc++;
         m_state = seed_load ? ((seed_in == 13'd0) ? 13'h000F : seed_in) : step(m_state);
         for (int i = 0; i < N; i++) begin
            if (m_idle[i]) begin
               if (req[i]) begin
                  predict(i);
                  m_idle[i] = 1'b0;
               end
            end else if (!m_valid[i]) begin
               if (sb[i].size() > 0 && sb[i][0].due == cyc) begin
                  m_cur[i]   = sb[i].pop_front();
                  m_valid[i] = 1'b1;
               end
            end else if (out_ready[i]) begin
               m_valid[i] = 1'b0;
               m_idle[i]  = 1'b1;
`ifdef RNG_STATS_EN
               m_draws[i]++;
`endif
            end
         end
      end
   end

   always @(negedge clock) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            check("mon_valid", 32'(ov[i]), 32'(m_valid[i]));
            check("mon_busy",  32'(bsy[i]), 32'(!m_idle[i]));
            check("mon_state", 32'(sq[i]), 32'(m_state));
            if (m_valid[i]) begin
               check("mon_data", 32'(od[i]), 32'(m_cur[i].d));
               check("mon_fb",   32'(fb[i]), 32'(m_cur[i].f));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_busy(input int i, input int budget);
      int n = 0;
      while (!bsy[i] && n < budget) begin tick(); n++; end
      check("busy_timeout", 32'(bsy[i]), 32'd1);
   endtask

   task automatic wait_valid(input int i, input int budget);
      int n = 0;
      while (!ov[i] && n < budget) begin tick(); n++; end
      check("valid_timeout", 32'(ov[i]), 32'd1);
   endtask

   initial begin
      logic [12:0] seq [4];
      logic [12:0] x;
      logic [12:0] found;
      logic [12:0] prev;
      logic [3:0]  hold_d;
      logic        hold_f;
      int          t0;

      seq[0] = 13'h000F; seq[1] = 13'h001E; seq[2] = 13'h003D; seq[3] = 13'h007B;
      reset = 1'b0; seed_load = 1'b0; seed_in = '0;
      for (int i = 0; i < N; i++) begin req[i] = 1'b0; out_ready[i] = 1'b0; end
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;

      check("rst_valid", 32'(ov[0]), 32'd0);
      check("rst_data",  32'(od[0]), 32'd0);
      check("rst_fb",    32'(fb[0]), 32'd0);
      check("rst_busy",  32'(bsy[0]), 32'd0);
      for (int j = 0; j < 4; j++) begin
         check("lfsr_seq", 32'(sq[0]), 32'(seq[j]));
         if (j < 3) tick();
      end

      seed_load = 1'b1; seed_in = 13'd0;
      tick();
      check("seed_zero", 32'(sq[0]), 32'h000F);
      seed_in = 13'h1ABC;
      tick();
      check("seed_load", 32'(sq[0]), 32'h1ABC);
      check("seed_busy", 32'(bsy[0]), 32'd0);
      seed_load = 1'b0;

      // Full range: every candidate accepted, fixed latency, IDLE gap
      req[1] = 1'b1; out_ready[1] = 1'b1;
      for (int d = 0; d < 3; d++) begin
         wait_busy(1, 5);
         t0 = cyc;
         wait_valid(1, 30);
         check("full_latency", 32'(cyc - t0), 32'(MIX + 1));
         check("full_fb", 32'(fb[1]), 32'd0);
         if (d == 2) req[1] = 1'b0;
         tick();
         check("gap_busy",  32'(bsy[1]), 32'd0);
         check("gap_valid", 32'(ov[1]), 32'd0);
      end
      out_ready[1] = 1'b0;

      // Single try: seed whose 13th successor ends in 0xC forces 12 % 5
      found = '0;
      for (int s = 1; s < 8192 && found == 13'd0; s++) begin
         x = 13'(s);
         for (int k = 0; k < MIX; k++) x = step(x);
         if (x[3:0] == 4'hC) found = 13'(s);
      end
      seed_load = 1'b1; seed_in = found; req[2] = 1'b1; out_ready[2] = 1'b1;
      tick();
      seed_load = 1'b0; req[2] = 1'b0;
      wait_valid(2, 20);
      check("fallback_data", 32'(od[2]), 32'd2);
      check("fallback_flag", 32'(fb[2]), 32'd1);
      tick();
      out_ready[2] = 1'b0;

      // Backpressure: output frozen, LFSR keeps running, seed load is harmless
      req[0] = 1'b1;
      wait_valid(0, 70);
      req[0] = 1'b0;
      hold_d = od[0]; hold_f = fb[0]; prev = sq[0];
      for (int j = 0; j < 10; j++) begin
         tick();
         check("hold_valid", 32'(ov[0]), 32'd1);
         check("hold_data",  32'(od[0]), 32'(hold_d));
         check("hold_fb",    32'(fb[0]), 32'(hold_f));
         check("hold_shift", 32'(sq[0] != prev), 32'd1);
         prev = sq[0];
         if (j == 4) begin
            check("hold_seed", 32'(sq[0]), 32'h1ABC);
            seed_load = 1'b0;
         end
         if (j == 3) begin seed_load = 1'b1; seed_in = 13'h1ABC; end
      end
      out_ready[0] = 1'b1;
      tick();
      check("ack_clear", 32'(ov[0]), 32'd0);
      out_ready[0] = 1'b0;

      // Random consumer traffic on two instances
      req[0] = 1'b1; req[2] = 1'b1;
      repeat (200) begin
         out_ready[0] = 1'($urandom_range(0, 1));
         out_ready[2] = 1'($urandom_range(0, 1));
         tick();
      end
      req[0] = 1'b0; req[2] = 1'b0;
      for (int i = 0; i < N; i++) out_ready[i] = 1'b1;
      repeat (70) tick();
      for (int i = 0; i < N; i++) check("drain_idle", 32'(bsy[i]), 32'd0);
`ifdef RNG_STATS_EN
      for (int i = 0; i < N; i++) begin
         check("stat_draws",   32'(dc[i]), 32'(m_draws[i]));
         check("stat_rejects", 32'(rc[i]), 32'(m_rej[i]));
      end
`endif
      for (int i = 0; i < N; i++) out_ready[i] = 1'b0;

      // Reset in the middle of a draw
      req[0] = 1'b1;
      tick();
      req[0] = 1'b0;
      repeat (4) tick();
      check("mid_busy", 32'(bsy[0]), 32'd1);
      reset = 1'b0;
      #1;
      check("mid_rst_busy",  32'(bsy[0]), 32'd0);
      check("mid_rst_valid", 32'(ov[0]), 32'd0);
      check("mid_rst_state", 32'(sq[0]), 32'h000F);
      tick();
      reset = 1'b1;
      tick();
      check("post_rst_shift", 32'(sq[0]), 32'h001E);
      check("post_rst_busy",  32'(bsy[0]), 32'd0);
`ifdef RNG_STATS_EN
      check("post_rst_rej", 32'(rc[0]), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
